// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional build macro honoured by the loader: LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = host/stream side (drives bytes, observes writes), slave = loader.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_adr;
  logic [31:0] wr_word;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_adr, wr_word
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_adr, wr_word
  );
endinterface

// File: rtl/imem_word_packer.sv
// Collects stream bytes MSB first into 32-bit words.
// complete/word_nxt are combinational so the loader can register the write
// on the same edge that accepts the last byte of a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        complete
);

  localparam int BC_W = $clog2(WORD_BYTES);

  logic [23:0]     shreg;
  logic [BC_W-1:0] cnt;

  assign complete = byte_en && (cnt == BC_W'(WORD_BYTES - 1));
  assign word_nxt = {shreg, byte_in};

  // shift accepted bytes in and count position within the current word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= {shreg[15:0], byte_in};
      cnt   <= cnt + BC_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + big-endian words -> instruction memory,
// holding the CPU in reset until the image is in place.
// Build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state  | meaning
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte; range check
// DATA   | assembling words, one write per 4 bytes
// CSUM   | waiting for trailing checksum byte
// DONE   | image loaded, CPU released
// ERR    | bad length or checksum, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
)
(
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  input  logic         reload,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t           state;
  logic             rx_ready_q;
  logic             wr_en_q;
  logic [31:0]      wr_adr_q;
  logic [31:0]      wr_word_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [7:0]       csum_q;

  logic             accept;
  logic             byte_en;
  logic             pk_clr;
  logic             pk_complete;
  logic [31:0]      pk_word;
  logic [CNT_W-1:0] len_rx;

  assign accept  = bus.rx_valid && rx_ready_q;
  assign byte_en = accept && (state == DATA);
  assign pk_clr  = reload && ((state == DONE) || (state == ERR));
  assign len_rx  = {len_q[CNT_W-1:8], bus.rx_data};

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_adr   = wr_adr_q;
  assign bus.wr_word  = wr_word_q;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .byte_en  (byte_en),
    .byte_in  (bus.rx_data),
    .word_nxt (pk_word),
    .complete (pk_complete)
  );

  // load sequencer; DONE/ERR flags settle one cycle after entering the state
  // so the release of cpu_hold follows the final write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LEN_HI;
      rx_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_word_q  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      len_q      <= '0;
      wcnt_q     <= '0;
      csum_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        LEN_HI: if (accept) begin
          len_q  <= {bus.rx_data, 8'h00};
          csum_q <= csum_q ^ bus.rx_data;
          state  <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          len_q  <= len_rx;
          csum_q <= csum_q ^ bus.rx_data;
          if (len_rx == '0) begin
            state      <= END_ST;
            rx_ready_q <= (END_ST == CSUM);
          end else if (len_rx > DEPTH_C) begin
            state      <= ERR;
            rx_ready_q <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          csum_q <= csum_q ^ bus.rx_data;
          if (pk_complete) begin
            wr_en_q   <= 1'b1;
            wr_word_q <= pk_word;
            wr_adr_q  <= 32'(wcnt_q) << 2;
            wcnt_q    <= wcnt_q + CNT_W'(1);
            if (wcnt_q == len_q - CNT_W'(1)) begin
              state      <= END_ST;
              rx_ready_q <= (END_ST == CSUM);
            end
          end
        end
        CSUM: if (accept) begin
          rx_ready_q <= 1'b0;
          state      <= (bus.rx_data == csum_q) ? DONE : ERR;
        end
        DONE, ERR: begin
          if (reload) begin
            state      <= LEN_HI;
            rx_ready_q <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_q      <= '0;
            wcnt_q     <= '0;
            csum_q     <= '0;
          end else begin
            rx_ready_q <= 1'b0;
            cpu_hold   <= (state == ERR);
            done       <= (state == DONE);
            err        <= (state == ERR);
          end
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus random images
// with random handshake gaps, compared against a stream-level model.
// Honours LOADER_CHECKSUM_EN in the same way as the design.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic cpu_hold, done, err;

  imem_loader_if bus_if ();

  imem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .reload   (reload),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // every write strobe seen, as {adr, word}
  logic [63:0] got_q[$];
  always @(negedge clk) if (bus_if.wr_en === 1'b1) got_q.push_back({bus_if.wr_adr, bus_if.wr_word});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, 64'(bus_if.rx_ready), 64'd1);
    check({tag, "_wr_en"},    64'(bus_if.wr_en),    64'd0);
    check({tag, "_wr_adr"},   64'(bus_if.wr_adr),   64'd0);
    check({tag, "_wr_word"},  64'(bus_if.wr_word),  64'd0);
    check({tag, "_cpu_hold"}, 64'(cpu_hold),        64'd1);
    check({tag, "_done"},     64'(done),            64'd0);
    check({tag, "_err"},      64'(err),             64'd0);
  endtask

  // called just after a negedge; returns just after the negedge following acceptance
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int t;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    t = 0;
    repeat (gap) begin
      bus_if.rx_valid = 1'b0;
      bus_if.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    while (bus_if.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rx_ready_timeout", 64'(bus_if.rx_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic reload_pulse(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_reload_rx_ready"}, 64'(bus_if.rx_ready), 64'd1);
    check({tag, "_reload_done"},     64'(done),            64'd0);
    check({tag, "_reload_err"},      64'(err),             64'd0);
    check({tag, "_reload_cpu_hold"}, 64'(cpu_hold),        64'd1);
  endtask

  // model: stream = len header, words (if 0 < n <= DEPTH), optional xor byte
  task automatic run_image(input string tag, input int n, input logic [7:0] data[$],
                           input int gap_max, input bit bad_csum);
    logic [7:0]  s[$];
    logic [63:0] exp_w[$];
    logic [15:0] nn;
    logic [7:0]  x;
    bit          exp_ok;
    int          t;
    nn = 16'(n);
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    exp_ok = 1'b1;
    if (n > DEPTH) begin
      exp_ok = 1'b0;
    end else begin
      for (int i = 0; i < n * 4; i++) s.push_back(data[i]);
      for (int k = 0; k < n; k++)
        exp_w.push_back({32'(k * 4), data[4*k], data[4*k+1], data[4*k+2], data[4*k+3]});
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      if (bad_csum) x = x ^ 8'h10;
      exp_ok = !bad_csum;
      s.push_back(x);
`else
      x = 8'h00;
      if (bad_csum) x = 8'h00;
`endif
    end
    got_q.delete();
    foreach (s[i]) send_byte(s[i], gap_max);
    bus_if.rx_valid = 1'b0;
`ifndef LOADER_CHECKSUM_EN
    if (exp_ok && n > 0) begin
      check({tag, "_last_wr_en"}, 64'(bus_if.wr_en), 64'd1);
      check({tag, "_done_early"}, 64'(done),         64'd0);
      @(negedge clk);
      check({tag, "_done_next"},     64'(done),            64'd1);
      check({tag, "_hold_next"},     64'(cpu_hold),        64'd0);
      check({tag, "_rx_ready_next"}, 64'(bus_if.rx_ready), 64'd0);
      check({tag, "_wr_en_next"},    64'(bus_if.wr_en),    64'd0);
    end
`endif
    t = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_w[i]);
    check({tag, "_done"},     64'(done),            64'(exp_ok));
    check({tag, "_err"},      64'(err),             64'(!exp_ok));
    check({tag, "_cpu_hold"}, 64'(cpu_hold),        64'(!exp_ok));
    check({tag, "_rx_ready"}, 64'(bus_if.rx_ready), 64'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    logic [7:0] d[$];
    logic [7:0] part[$];
    int n;

    img  = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    rst  = 1'b1;
    reload = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_reset");

    run_image("s1_two_words", 2, img, 0, 1'b0);
    reload_pulse("s1");

    d.delete();
    run_image("s2_empty", 0, d, 0, 1'b0);
    reload_pulse("s2");

    run_image("s3_too_long", DEPTH + 1, d, 0, 1'b0);
    reload_pulse("s3");

    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_image("s4_bad_csum", 1, d, 0, 1'b1);
    reload_pulse("s4a");
    run_image("s4_good_csum", 1, d, 0, 1'b0);
    reload_pulse("s4b");

    run_image("s5_gaps", 2, img, 5, 1'b0);
    reload_pulse("s5");

    // s6: reset after 2 bytes of word 1
    part = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    got_q.delete();
    foreach (part[i]) send_byte(part[i], 0);
    bus_if.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("s6_midreset");
    check("s6_nwr", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check("s6_wr0", got_q[0], 64'h00000000_20080005);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_image("s6_resend", 2, img, 0, 1'b0);
    reload_pulse("s6");

    // boundary: exactly DEPTH words
    d.delete();
    for (int i = 0; i < DEPTH * 4; i++) d.push_back(8'($urandom));
    run_image("full_depth", DEPTH, d, 0, 1'b0);
    reload_pulse("full");

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(6, 0));
      d.delete();
      for (int i = 0; i < n * 4; i++) d.push_back(8'($urandom));
      run_image($sformatf("rand%0d", it), n, d, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      reload_pulse($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
